main_memory_ctrl: RTL and testbench
===================================

Name: main_memory_ctrl

Overview:
- Shared main-memory block directly downstream of the cache controller/datapath.
- Services block-granular reads and writes: one 32-bit block per 6-bit block address, over the cache's memory handshake (mem_cs, mem_rd, mem_wr, mem_ready) and the shared b_addr/b_data bus.
- Models a fixed access latency so cache miss/write-back paths see realistic multi-cycle stalls.

Parameters:
- ADDR_W, 6: block address width; array depth is 2**ADDR_W.
- DATA_W, 32: block data width.
- LATENCY, 4: cycles from request acceptance to mem_ready; legal range 1..15.

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_cs  input  1  chip select from cache controller.
- mem_rd  input  1  read request; qualified by mem_cs.
- mem_wr  input  1  write request; qualified by mem_cs.
- b_addr  input  ADDR_W  block address from cache datapath.
- b_data  inout  DATA_W  block data bus: driven by the cache on writes, by this block on reads, hi-Z otherwise.
- mem_ready  output  1  one-cycle completion pulse.
- mem_busy  output  1  high from request acceptance until release; for debug and arbitration.

Behaviour:
- Storage: 2**ADDR_W x DATA_W array. Reset loads word i with the value i, zero-extended, so word 6'h2A = 32'h0000_002A.
- Reset (asynchronous, any time, including mid-access):
  - state=IDLE, mem_ready=0, mem_busy=0, b_data released (hi-Z), counter=0.
  - Array reloads its reset pattern; any in-flight write is discarded.
- States: IDLE, BUSY, DONE, RELEASE.
- IDLE:
  - Accept when mem_cs=1 and exactly one of mem_rd/mem_wr is 1.
  - On accept: latch b_addr, the op, and (for writes) b_data; counter=LATENCY-1; mem_busy=1; go BUSY.
  - mem_cs=1 with rd=wr (both 0 or both 1): not accepted, no state change, mem_ready stays 0.
- BUSY:
  - Counter decrements each cycle.
  - When counter==0: a write commits the latched data to array[latched addr]; a read loads array[latched addr] into the read register; go DONE.
  - Inputs are ignored while BUSY; bus changes after acceptance do not affect the access.
- DONE (exactly one cycle):
  - mem_ready=1.
  - For a read, b_data is driven with the read register.
  - Go RELEASE.
- RELEASE:
  - mem_ready=0, b_data hi-Z.
  - Stay until mem_cs=0, then go IDLE with mem_busy=0.
  - A request held across DONE is therefore never re-serviced.
- Latency: acceptance edge at cycle 0 gives mem_ready high during cycle LATENCY, i.e. LATENCY=1 means ready on the cycle after acceptance.
- Read data timing: b_data holds valid read data during exactly the mem_ready cycle; the cache samples it on the edge that ends that cycle.
- Read-after-write to the same address returns the new data (the write commits before DONE).
- Bus drive: b_data is never driven outside DONE-for-read. No contention on the write path.
- mem_cs dropped while BUSY: the access still completes, mem_ready still pulses, then RELEASE exits immediately.
- No address wrap concerns: b_addr covers the full array exactly.

Test Plan:
1. Reset release, then read addr 6'h2A, LATENCY=4 -> mem_ready high exactly 4 cycles after acceptance with b_data=32'h0000_002A; b_data is Z the cycle before and the cycle after.
2. Write 32'hDEAD_BEEF to 6'h05, drop mem_cs after ready, then read 6'h05 -> read returns 32'hDEAD_BEEF; mem_ready pulses once per access.
3. Hold mem_cs=1, mem_rd=1 for 10 cycles continuously -> exactly one mem_ready pulse; mem_busy stays 1 until mem_cs falls.
4. mem_cs=1 with mem_rd=mem_wr=1 for 5 cycles -> state stays IDLE, mem_busy=0, no mem_ready, b_data Z.
5. Assert reset during BUSY of a write of 32'h1234_5678 to 6'h3F -> mem_ready never pulses; a subsequent read of 6'h3F returns 32'h0000_003F.
6. Re-elaborate with LATENCY=1 and issue back-to-back reads of 6'h00 then 6'h01 -> ready one cycle after each acceptance, data 32'h0 then 32'h1.

Source files
------------

// File: rtl/mem_if.sv
// Cache-to-main-memory handshake bundle: request strobes, block address and
// completion/busy status. The shared block data bus stays a separate inout.
interface mem_if #(
  parameter int ADDR_W = 6
);
  logic              mem_cs;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] b_addr;
  logic              mem_ready;
  logic              mem_busy;

  modport master (
    output mem_cs, mem_rd, mem_wr, b_addr,
    input  mem_ready, mem_busy
  );

  modport slave (
    input  mem_cs, mem_rd, mem_wr, b_addr,
    output mem_ready, mem_busy
  );
endinterface

// File: rtl/main_memory_ctrl.sv
// Block-granular main memory with a fixed access latency. Serves one read or
// write per handshake and releases only after the cache drops mem_cs.
module main_memory_ctrl #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_if.slave              bus,
  inout  wire  [DATA_W-1:0] b_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_DONE    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                is_wr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                ready_r;
  logic                busy_r;
  logic                drive_r;
  logic                accept_s;
  logic                commit_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];

  // Next-state decode; commit_s marks the single cycle the array is accessed
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.mem_cs && (bus.mem_rd ^ bus.mem_wr)) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          commit_s    = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!bus.mem_cs) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RELEASE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, request latches, latency counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      is_wr_r <= 1'b0;
      wdata_r <= {DATA_W{1'b0}};
      rdata_r <= {DATA_W{1'b0}};
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      drive_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_DONE);
      busy_r  <= (state_nxt_s != ST_IDLE);
      // is_wr_r is stable here: DONE is only ever entered from BUSY
      drive_r <= (state_nxt_s == ST_DONE) && !is_wr_r;
      if (accept_s) begin
        addr_r  <= bus.b_addr;
        is_wr_r <= bus.mem_wr;
        wdata_r <= b_data;
        cnt_r   <= CNT_W'(LATENCY - 1);
      end else if ((state_r == ST_BUSY) && (cnt_r != {CNT_W{1'b0}})) begin
        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
      if (commit_s && !is_wr_r) begin
        rdata_r <= mem_r[addr_r];
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  // Storage array; reset restores the identity pattern and drops any pending write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= DATA_W'(i);
      end
    end else if (commit_s && is_wr_r) begin
      mem_r[addr_r] <= wdata_r;
    end else begin
      mem_r[addr_r] <= mem_r[addr_r];
    end
  end

  assign b_data        = drive_r ? rdata_r : {DATA_W{1'bz}};
  assign bus.mem_ready = ready_r;
  assign bus.mem_busy  = busy_r;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench: table vectors, hand-written corner sequences and random
// traffic against an array model, on a LATENCY=4 and a LATENCY=1 instance.
module tb_main_memory_ctrl;

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  typedef struct {
    int          s;
    bit          w;
    logic [5:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_v [2];
  logic        rd_v [2];
  logic        wr_v [2];
  logic [5:0]  addr_v [2];
  logic [31:0] tdata [2];
  logic        tdrv [2];
  int          lat_exp [2];
  logic [31:0] model [2][64];
  int          n_checks = 0;
  int          n_errors = 0;

  // Undriven bus reads as all ones, which makes hi-Z observable
  tri1 [31:0] bus_a;
  tri1 [31:0] bus_b;

  mem_if #(.ADDR_W(6)) ifa ();
  mem_if #(.ADDR_W(6)) ifb ();

  assign ifa.mem_cs = cs_v[0];
  assign ifa.mem_rd = rd_v[0];
  assign ifa.mem_wr = wr_v[0];
  assign ifa.b_addr = addr_v[0];
  assign ifb.mem_cs = cs_v[1];
  assign ifb.mem_rd = rd_v[1];
  assign ifb.mem_wr = wr_v[1];
  assign ifb.b_addr = addr_v[1];
  assign bus_a = tdrv[0] ? tdata[0] : 32'hzzzz_zzzz;
  assign bus_b = tdrv[1] ? tdata[1] : 32'hzzzz_zzzz;

  main_memory_ctrl #(.ADDR_W(6), .DATA_W(32), .LATENCY(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa), .b_data(bus_a)
  );

  main_memory_ctrl #(.ADDR_W(6), .DATA_W(32), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb), .b_data(bus_b)
  );

  always #5 clk = ~clk;

  function automatic logic rdy(input int s);
    return (s == 1) ? ifb.mem_ready : ifa.mem_ready;
  endfunction

  function automatic logic bsy(input int s);
    return (s == 1) ? ifb.mem_busy : ifa.mem_busy;
  endfunction

  function automatic logic [31:0] bval(input int s);
    return (s == 1) ? bus_b : bus_a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 64; i++)
        model[s][i] = 32'(i);
  endtask

  // Full handshake; caller is between a negedge and the next posedge
  task automatic access(input int s, input bit w, input logic [5:0] a,
                        input logic [31:0] d, input logic [31:0] exp, input string nm);
    bit seen;
    int k;
    cs_v[s] = 1'b1; rd_v[s] = !w; wr_v[s] = w; addr_v[s] = a;
    tdata[s] = d; tdrv[s] = w;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      if (k == 0) begin
        addr_v[s] = ~a; rd_v[s] = w; wr_v[s] = !w; tdata[s] = ~d;
      end
      if (rdy(s)) begin
        seen = 1'b1;
        tdrv[s] = 1'b0;
      end
      #1;
      if (k == 0) chk({nm, " busy"}, 32'(bsy(s)), 32'd1);
      if (seen) begin
        chk({nm, " latency"}, 32'(k), 32'(lat_exp[s]));
        chk({nm, " data"}, bval(s), w ? ONES : exp);
      end else if (!w) begin
        chk({nm, " z before"}, bval(s), ONES);
      end
      if (!seen) k++;
    end
    if (!seen) chk({nm, " ready timeout"}, 32'd0, 32'd1);
    cs_v[s] = 1'b0; rd_v[s] = 1'b0; wr_v[s] = 1'b0; tdrv[s] = 1'b0;
    @(negedge clk); #1;
    chk({nm, " ready pulse"}, 32'(rdy(s)), 32'd0);
    chk({nm, " z after"}, bval(s), ONES);
    @(negedge clk); #1;
    chk({nm, " busy release"}, 32'(bsy(s)), 32'd0);
  endtask

  vec_t tbl [8];

  initial begin
    int pulses;
    lat_exp[0] = 4;
    lat_exp[1] = 1;
    for (int s = 0; s < 2; s++) begin
      cs_v[s] = 1'b0; rd_v[s] = 1'b0; wr_v[s] = 1'b0;
      addr_v[s] = 6'd0; tdata[s] = 32'd0; tdrv[s] = 1'b0;
    end
    model_reset();

    tbl[0] = '{s: 0, w: 1'b0, a: 6'h2A, d: 32'h0,         exp: 32'h0000_002A};
    tbl[1] = '{s: 0, w: 1'b1, a: 6'h05, d: 32'hDEAD_BEEF, exp: 32'h0};
    tbl[2] = '{s: 0, w: 1'b0, a: 6'h05, d: 32'h0,         exp: 32'hDEAD_BEEF};
    tbl[3] = '{s: 0, w: 1'b0, a: 6'h3F, d: 32'h0,         exp: 32'h0000_003F};
    tbl[4] = '{s: 1, w: 1'b0, a: 6'h00, d: 32'h0,         exp: 32'h0000_0000};
    tbl[5] = '{s: 1, w: 1'b0, a: 6'h01, d: 32'h0,         exp: 32'h0000_0001};
    tbl[6] = '{s: 1, w: 1'b1, a: 6'h01, d: 32'h0BAD_F00D, exp: 32'h0};
    tbl[7] = '{s: 1, w: 1'b0, a: 6'h01, d: 32'h0,         exp: 32'h0BAD_F00D};

    reset = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("reset busy", 32'(ifa.mem_busy), 32'd0);
    chk("reset ready", 32'(ifa.mem_ready), 32'd0);
    chk("reset bus z", bus_a, ONES);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      access(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp, $sformatf("vec%0d", i));
      if (tbl[i].w) model[tbl[i].s][tbl[i].a] = tbl[i].d;
    end

    // Request held across DONE is serviced once; busy holds until mem_cs falls
    cs_v[0] = 1'b1; rd_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 6'h10;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (ifa.mem_ready) begin
        pulses++;
        chk("held data", bus_a, model[0][16]);
      end
      chk("held busy", 32'(ifa.mem_busy), 32'd1);
    end
    chk("held pulses", 32'(pulses), 32'd1);
    cs_v[0] = 1'b0; rd_v[0] = 1'b0;
    @(negedge clk); #1;
    chk("held busy drop", 32'(ifa.mem_busy), 32'd0);

    // Ambiguous requests (rd==wr) are never accepted
    for (int i = 0; i < 8; i++) begin
      cs_v[0] = 1'b1; rd_v[0] = (i < 5); wr_v[0] = (i < 5); addr_v[0] = 6'(i);
      @(negedge clk); #1;
      chk("ambig ready", 32'(ifa.mem_ready), 32'd0);
      chk("ambig busy", 32'(ifa.mem_busy), 32'd0);
      chk("ambig z", bus_a, ONES);
    end
    cs_v[0] = 1'b0; rd_v[0] = 1'b0; wr_v[0] = 1'b0;
    @(negedge clk); #1;

    // Reset in the middle of a write discards it
    cs_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 6'h3F;
    tdata[0] = 32'h1234_5678; tdrv[0] = 1'b1;
    @(negedge clk);
    cs_v[0] = 1'b0; wr_v[0] = 1'b0; tdrv[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async rst busy", 32'(ifa.mem_busy), 32'd0);
    chk("async rst ready", 32'(ifa.mem_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (ifa.mem_ready) pulses++;
    end
    chk("rst no ready", 32'(pulses), 32'd0);
    access(0, 1'b0, 6'h3F, 32'h0, 32'h0000_003F, "post rst read");

    // Random traffic on both instances against the array model
    for (int i = 0; i < 40; i++) begin
      int s;
      bit w;
      logic [5:0] a;
      logic [31:0] d;
      s = int'($urandom_range(1, 0));
      w = 1'($urandom_range(1, 0));
      a = 6'($urandom_range(63, 0));
      d = $urandom;
      if (d == ONES) d = 32'h0;
      access(s, w, a, d, model[s][a], $sformatf("rand%0d", i));
      if (w) model[s][a] = d;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
